mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
// - Memory-access stage: consumer of the execute stage's memory request (address, dm_we, dm_access_size, rw_d, rt store data).
// - Drives a request/acknowledge data-memory port, aligns byte/half/word lanes (big-endian), sign/zero-extends loads.
// - Presents a registered result to writeback; stalls execute while a memory transaction is outstanding.
// PARAMETERS
// - BIG_ENDIAN   1   1: byte offset 0 maps to bits [31:24]; 0: byte offset 0 maps to bits [7:0]
// - TIMEOUT      16  max cycles waiting for mem_ack before bus error (>=2)
// PORTS
// - clock          in   1   sole clock, rising edge
// - reset          in   1   synchronous, active-high
// - ex_valid       in   1   execute presents an instruction this cycle
// - ex_ready       out  1   stage accepts ex_* this cycle (transfer = ex_valid & ex_ready)
// - ex_addr        in   32  ALU result: effective address or non-memory result
// - ex_store_data  in   32  rt value for stores
// - ex_dm_we       in   1   1 = store
// - ex_rw_d        in   1   1 = load (result comes from memory)
// - ex_access_size in   2   00 word, 01 half, 10 byte, 11 reserved
// - ex_unsigned    in   1   zero-extend load (LBU/LHU)
// - ex_rd          in   5   destination register
// - ex_reg_we      in   1   instruction writes a register
// - mem_req        out  1   memory request valid
// - mem_we         out  1   request is a write
// - mem_addr       out  32  word-aligned address ({ex_addr[31:2],2'b00})
// - mem_wdata      out  32  store data replicated/shifted into its lanes
// - mem_be         out  4   byte enables (bit3 = bits[31:24])
// - mem_ack        in   1   memory completes request this cycle
// - mem_rdata      in   32  read word, valid with mem_ack
// - wb_valid       out  1   result valid for writeback (one-cycle pulse per instruction)
// - wb_data        out  32  load result or passed-through ALU result
// - wb_rd          out  5   destination register
// - wb_we          out  1   regfile write enable (0 on store or error)
// - addr_err       out  1   one-cycle pulse: misaligned or reserved-size access
// - bus_err        out  1   one-cycle pulse: mem_ack timeout
// BEHAVIOUR
// - Reset: state IDLE; ex_ready=1; mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0; wb_valid=0, wb_we=0, wb_data=0, wb_rd=0; addr_err=0, bus_err=0; timeout counter 0.
// - FSM IDLE -> REQ -> IDLE. ex_ready = (state==IDLE).
// - IDLE, transfer of non-memory op (!ex_dm_we & !ex_rw_d): next cycle wb_valid=1, wb_data=ex_addr, wb_we=ex_reg_we. Latency 1.
// - IDLE, transfer of memory op: alignment check first: half needs addr[0]=0, word needs addr[1:0]=0, size 11 illegal.
//   - Fault: next cycle addr_err=1, wb_valid=1, wb_we=0, no mem_req; stay IDLE.
//   - Ok: next cycle mem_req=1 with mem_we/addr/be/wdata registered; go REQ; counter cleared.
// - REQ: all mem_* outputs held stable until mem_ack. On mem_ack: mem_req=0 next cycle, wb_valid=1, wb_rd captured rd,
//   wb_we = load ? reg_we : 0, wb_data = aligned load value (stores: wb_data=0); return IDLE. Load latency = 1 + wait + 1.
// - Timeout: counter increments each REQ cycle without ack; at TIMEOUT-1 with no ack -> drop mem_req, bus_err=1, wb_valid=1, wb_we=0, IDLE.
//   mem_ack arriving in IDLE is ignored.
// - Lanes (BIG_ENDIAN=1): byte k=addr[1:0] -> be=4'b1000>>k, data bits [31-8k -: 8]; half addr[1]=0 -> be=1100 bits[31:16],
//   addr[1]=1 -> be=0011 bits[15:0]; word -> be=1111. BIG_ENDIAN=0 mirrors lane index.
// - Store wdata: byte replicated x4, half replicated x2, word as-is. Load: selected lane, sign-extend unless ex_unsigned.
// - ex_valid while !ex_ready: inputs held by execute, not sampled. Back-to-back accepted ops in IDLE give back-to-back wb_valid.
// - Reset asserted mid-REQ: abandons transaction, mem_req=0 next cycle, no wb_valid, no error pulses.
// STRUCTURE
// - Shared package mips_pkg: access-size codes (SZ_WORD/SZ_HALF/SZ_BYTE), FSM state encoding, TIMEOUT default.
// - Sub-module mem_lane_align (combinational): size, addr[1:0], unsigned, store data, rdata -> be, wdata, load result, misalign flag.
// TESTING
// - Word store addr 0x100, data 0xDEADBEEF, ack after 2 cycles -> mem_be=1111, mem_addr=0x100, ex_ready low 3 cycles, wb_we=0.
// - LB addr 0x103, rdata 0x123456F0 -> wb_data 0xFFFFFFF0; LBU same -> 0x000000F0; LH 0x102 rdata 0x1234_8001 -> 0xFFFF8001.
// - SB addr 0x101 data 0x000000AB -> mem_be=0100, mem_wdata=0xABABABAB, mem_addr=0x100.
// - LW addr 0x102 -> addr_err pulse, no mem_req, wb_valid=1 wb_we=0 one cycle later; size 11 also addr_err.
// - No ack for TIMEOUT cycles -> bus_err pulse, mem_req drops, ex_ready returns 1; later stray ack ignored.
// - Reset during REQ, then ADD result 0x5 to rd=3 -> no stale wb; next cycle wb_valid, wb_data=0x5, wb_rd=3, wb_we=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the memory-access stage: access-size codes,
// stage FSM states and the default bus-timeout.
package mips_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } access_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } mem_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data,
// load lane extraction with sign/zero extension, and alignment check.
module mem_lane_align
    import mips_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  access_size_e size,
    input  logic [1:0]   addr_lo,
    input  logic         is_unsigned,
    input  logic [31:0]  store_data,
    input  logic [31:0]  rdata,
    output logic [3:0]   be,
    output logic [31:0]  wdata,
    output logic [31:0]  load_data,
    output logic         misalign
);

    logic [1:0]  byte_lane;
    logic        half_lane;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Physical lane index: big-endian puts offset 0 in the top lane.
    assign byte_lane = BIG_ENDIAN ? ~addr_lo : addr_lo;
    assign half_lane = BIG_ENDIAN ? ~addr_lo[1] : addr_lo[1];
    assign rd_byte   = rdata[{byte_lane, 3'b000} +: 8];
    assign rd_half   = rdata[{half_lane, 4'b0000} +: 16];

    always_comb begin
        be        = '0;
        wdata     = '0;
        load_data = '0;
        misalign  = 1'b0;
        case (size)
            SZ_WORD: begin
                be        = '1;
                wdata     = store_data;
                load_data = rdata;
                misalign  = |addr_lo;
            end
            SZ_HALF: begin
                be        = half_lane ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = is_unsigned ? {16'h0000, rd_half}
                                        : {{16{rd_half[15]}}, rd_half};
                misalign  = addr_lo[0];
            end
            SZ_BYTE: begin
                be        = 4'b0001 << byte_lane;
                wdata     = {4{store_data[7:0]}};
                load_data = is_unsigned ? {24'h000000, rd_byte}
                                        : {{24{rd_byte[7]}}, rd_byte};
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one request/acknowledge transaction
// per load/store, aligns data lanes and presents a registered writeback result.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter bit          BIG_ENDIAN = 1'b1,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    input  logic        ex_dm_we,
    input  logic        ex_rw_d,
    input  logic [1:0]  ex_access_size,
    input  logic        ex_unsigned,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic        addr_err,
    output logic        bus_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    mem_state_e     state;
    logic [CNT_W-1:0] cnt;

    access_size_e   req_size;
    logic [1:0]     req_lo;
    logic           req_unsigned;
    logic           req_is_load;
    logic           req_reg_we;
    logic [4:0]     req_rd;

    access_size_e   al_size;
    logic [1:0]     al_lo;
    logic           al_unsigned;
    logic [3:0]     al_be;
    logic [31:0]    al_wdata;
    logic [31:0]    al_load;
    logic           al_misalign;
    logic           transfer;
    logic           is_mem;

    // One aligner serves both phases: request fields from execute while idle,
    // the captured request while waiting so the load lane matches the address.
    assign al_size     = (state == ST_REQ) ? req_size : access_size_e'(ex_access_size);
    assign al_lo       = (state == ST_REQ) ? req_lo : ex_addr[1:0];
    assign al_unsigned = (state == ST_REQ) ? req_unsigned : ex_unsigned;

    mem_lane_align #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_align (
        .size       (al_size),
        .addr_lo    (al_lo),
        .is_unsigned(al_unsigned),
        .store_data (ex_store_data),
        .rdata      (mem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misalign   (al_misalign)
    );

    assign ex_ready = (state == ST_IDLE);
    assign transfer = ex_valid & ex_ready;
    assign is_mem   = ex_dm_we | ex_rw_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_we        <= 1'b0;
            addr_err     <= 1'b0;
            bus_err      <= 1'b0;
            req_size     <= SZ_WORD;
            req_lo       <= '0;
            req_unsigned <= 1'b0;
            req_is_load  <= 1'b0;
            req_reg_we   <= 1'b0;
            req_rd       <= '0;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            addr_err <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (transfer) begin
                        if (!is_mem) begin
                            wb_valid <= 1'b1;
                            wb_data  <= ex_addr;
                            wb_rd    <= ex_rd;
                            wb_we    <= ex_reg_we;
                        end else if (al_misalign) begin
                            addr_err <= 1'b1;
                            wb_valid <= 1'b1;
                            wb_data  <= '0;
                            wb_rd    <= ex_rd;
                        end else begin
                            mem_req      <= 1'b1;
                            mem_we       <= ex_dm_we;
                            mem_addr     <= {ex_addr[31:2], 2'b00};
                            mem_be       <= al_be;
                            mem_wdata    <= al_wdata;
                            req_size     <= access_size_e'(ex_access_size);
                            req_lo       <= ex_addr[1:0];
                            req_unsigned <= ex_unsigned;
                            req_is_load  <= ex_rw_d & ~ex_dm_we;
                            req_reg_we   <= ex_reg_we;
                            req_rd       <= ex_rd;
                            cnt          <= '0;
                            state        <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // An ack in the final allowed cycle still completes normally.
                    if (mem_ack || (cnt == CNT_W'(TIMEOUT - 1))) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= '0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        wb_valid  <= 1'b1;
                        wb_rd     <= req_rd;
                        cnt       <= '0;
                        state     <= ST_IDLE;
                        if (mem_ack) begin
                            wb_we   <= req_is_load & req_reg_we;
                            wb_data <= req_is_load ? al_load : '0;
                        end else begin
                            bus_err <= 1'b1;
                            wb_data <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
